sha256_padder: RTL

// Message-preprocessing stage directly upstream of the SHA-256 compression block.

---
 rtl/sha256_pkg.sv | 41 ++++
 rtl/sha256_padder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants and padder state encoding
// Purpose: word/block geometry, padding marker, padder FSM states, and the
//          initial hash value and round constants used by the hasher.
// Ports:   none (package).
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam logic [WORD_W-1:0] PAD_MARKER = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_EMIT = 2'd2
  } pad_state_e;

  localparam logic [WORD_W-1:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - SHA-256 message padder producing 512-bit blocks
// Purpose: collects big-endian 32-bit message words, appends the 0x80 marker,
//          zero fill and the message bit length, and emits 512-bit blocks
//          tagged first/last for the compression block.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   in_data/in_valid/in_ready/in_last/in_bytes   message word stream
//   blk_data/blk_valid/blk_ready/blk_first/blk_last  padded block stream
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_first,
  output logic         blk_last
);

  pad_state_e state_q, state_d;
  logic [WORD_W-1:0] wbuf_q [BLOCK_WORDS];
  logic [WORD_W-1:0] wbuf_d [BLOCK_WORDS];
  logic [3:0]        wr_idx_q, wr_idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              marker_done_q, marker_done_d;
  logic              pad_pending_q, pad_pending_d;
  logic              last_q, last_d;
  logic              first_q, first_d;

  logic [2:0]        nbytes;
  logic [WORD_W-1:0] last_word;
  logic [63:0]       len64;

  always_comb begin
    // Anything above 4 bytes means a full word.
    nbytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    len64  = 64'(len_q);
    case (nbytes)
      3'd0:    last_word = PAD_MARKER;
      3'd1:    last_word = {in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data[31:16], 16'h8000};
      3'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    wbuf_d        = wbuf_q;
    wr_idx_d      = wr_idx_q;
    len_d         = len_q;
    marker_done_d = marker_done_q;
    pad_pending_d = pad_pending_q;
    last_d        = last_q;
    first_d       = first_q;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          wr_idx_d = wr_idx_q + 4'd1;
          if (!in_last) begin
            wbuf_d[wr_idx_q] = in_data;
            len_d            = len_q + LEN_W'(32);
            if (wr_idx_q == 4'd15) begin
              state_d       = S_EMIT;
              last_d        = 1'b0;
              pad_pending_d = 1'b0;
            end
          end else begin
            wbuf_d[wr_idx_q] = last_word;
            marker_done_d    = (nbytes != 3'd4);
            len_d            = len_q + LEN_W'({nbytes, 3'b000});
            if (wr_idx_q == 4'd15) begin
              // Block full: the marker and/or length go into the next block.
              state_d       = S_EMIT;
              last_d        = 1'b0;
              pad_pending_d = 1'b1;
            end else begin
              state_d = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        if (marker_done_q && (wr_idx_q == 4'd14)) begin
          wbuf_d[14]    = len64[63:32];
          wbuf_d[15]    = len64[31:0];
          state_d       = S_EMIT;
          last_d        = 1'b1;
          pad_pending_d = 1'b0;
        end else begin
          wbuf_d[wr_idx_q] = marker_done_q ? '0 : PAD_MARKER;
          marker_done_d    = 1'b1;
          wr_idx_d         = wr_idx_q + 4'd1;
          if (wr_idx_q == 4'd15) begin
            // No room left for the length: finish it in a follow-on block.
            state_d       = S_EMIT;
            last_d        = 1'b0;
            pad_pending_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (blk_ready) begin
          wr_idx_d = 4'd0;
          if (last_q) begin
            state_d       = S_FILL;
            len_d         = '0;
            first_d       = 1'b1;
            marker_done_d = 1'b0;
            pad_pending_d = 1'b0;
            last_d        = 1'b0;
          end else begin
            first_d = 1'b0;
            state_d = pad_pending_q ? S_PAD : S_FILL;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FILL;
      wr_idx_q      <= '0;
      len_q         <= '0;
      marker_done_q <= 1'b0;
      pad_pending_q <= 1'b0;
      last_q        <= 1'b0;
      first_q       <= 1'b1;
      for (int i = 0; i < BLOCK_WORDS; i++) wbuf_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      len_q         <= len_d;
      marker_done_q <= marker_done_d;
      pad_pending_q <= pad_pending_d;
      last_q        <= last_d;
      first_q       <= first_d;
      for (int i = 0; i < BLOCK_WORDS; i++) wbuf_q[i] <= wbuf_d[i];
    end
  end

  always_comb begin
    blk_data = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) blk_data[511-32*i -: 32] = wbuf_q[i];
  end

  assign in_ready  = (state_q == S_FILL);
  assign blk_valid = (state_q == S_EMIT);
  assign blk_first = first_q;
  assign blk_last  = last_q;

endmodule
